// File: rtl/single_port_ram.sv
// Synchronous single-port RAM with write-first registered read data and async active-high reset.
// Define SINGLE_PORT_RAM_MEM_CLEAR_EN to also clear the array while rst is high.
module single_port_ram #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] val,
  // Last in the list so that 5-port positional instances still bind; tie low when unused.
  input  logic                  rst
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef SINGLE_PORT_RAM_MEM_CLEAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= data;
    end
  end
`else
  logic wr_en;

  // Writes are blocked while rst is high even though the array itself is never reset.
  assign wr_en = we & ~rst;

  // NOTE: the array has no reset here so synthesis can map it onto block RAM;
  // unwritten words read as X in simulation.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= data;
    end
  end
`endif

  // NOTE: non-blocking assignments keep the read of mem[addr] seeing the pre-edge contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val <= '0;
    end else if (we) begin
      val <= data;
    end else begin
      val <= mem[addr];
    end
  end

endmodule

// File: tb/tb_single_port_ram.sv
// Directed self-checking bench for single_port_ram (64 x 8 default configuration).
// Honours SINGLE_PORT_RAM_MEM_CLEAR_EN for the post-reset array contents.
module tb_single_port_ram;

  localparam int ADDR_WIDTH = 6;
  localparam int DATA_WIDTH = 8;

  logic                  clk;
  logic                  rst;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] val;

  int vectors;
  int miscompares;

  single_port_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk (clk),
    .we  (we),
    .addr(addr),
    .data(data),
    .val (val),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where outputs are stable.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_WIDTH-1:0] observed,
                       input logic [DATA_WIDTH-1:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b1;
    we   = 1'b0;
    addr = '0;
    data = '0;

    // Reset held across an edge
    cycle();
    check("reset_initial", val, 8'h00);

    // First edge after release is a normal write
    rst  = 1'b0;
    we   = 1'b1;
    addr = 6'd20;
    data = 8'h11;
    cycle();
    check("write_after_release", val, 8'h11);

    // Mid-cycle reset: val clears before the next edge, and the pending write is ignored
    addr = 6'd20;
    data = 8'h77;
    #2;
    rst = 1'b1;
    #1;
    check("reset_async_clear", val, 8'h00);
    cycle();
    check("reset_hold_write", val, 8'h00);

    rst  = 1'b0;
    we   = 1'b0;
    addr = 6'd20;
    cycle();
`ifdef SINGLE_PORT_RAM_MEM_CLEAR_EN
    check("read20_after_reset", val, 8'h00);
    addr = 6'd10;
    cycle();
    check("read10_after_reset", val, 8'h00);
`else
    check("read20_after_reset", val, 8'h11);
`endif

    // Write sequence, write-first output
    we   = 1'b1;
    addr = 6'd4;
    data = 8'd44;
    cycle();
    check("write4", val, 8'd44);
    addr = 6'd19;
    data = 8'd45;
    cycle();
    check("write19", val, 8'd45);

    // Readback
    we   = 1'b0;
    addr = 6'd4;
    cycle();
    check("read4", val, 8'd44);
    addr = 6'd19;
    cycle();
    check("read19", val, 8'd45);

    // Overwrite and immediate read
    we   = 1'b1;
    addr = 6'd3;
    data = 8'd62;
    cycle();
    check("write3", val, 8'd62);
    we = 1'b0;
    cycle();
    check("read3", val, 8'd62);

    // Inputs changed between edges: only the values present at the edge count
    we   = 1'b1;
    addr = 6'd3;
    data = 8'd43;
    #3;
    addr = 6'd4;
    data = 8'd44;
    cycle();
    check("midcycle_write", val, 8'd44);
    we   = 1'b0;
    addr = 6'd3;
    cycle();
    check("midcycle_read3", val, 8'd62);
    addr = 6'd4;
    cycle();
    check("midcycle_read4", val, 8'd44);

    // Boundary addresses
    we   = 1'b1;
    addr = 6'd0;
    data = 8'hA5;
    cycle();
    check("write0", val, 8'hA5);
    addr = 6'd63;
    data = 8'h5A;
    cycle();
    check("write63", val, 8'h5A);
    we   = 1'b0;
    addr = 6'd0;
    cycle();
    check("read0", val, 8'hA5);
    addr = 6'd63;
    cycle();
    check("read63", val, 8'h5A);
    addr = 6'd19;
    cycle();
    check("read19_final", val, 8'd45);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
